aes_128_dec: RTL and testbench

- Iterative AES-128 inverse cipher. It is the decrypt-side counterpart of the existing aes_128 encryptor core.
- Takes a 128-bit ciphertext and cipher key, expands the key schedule on chip, then runs one inverse round per clock.
- Sits beside aes_128 under the top-level wrapper, so encrypt/decrypt round trips can be checked in silicon and in simulation.

---
 rtl/aes_dec_pkg.sv | 80 ++++++++
 rtl/aes_sbox.sv | 39 +++
 rtl/inv_sbox.sv | 39 +++
 rtl/aes_128_dec.sv | 175 +++++++++++++++++
 tb/tb_aes_128_dec.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_dec_pkg
//  Description : Shared types, constants and GF(2^8) helpers for the
//                AES-128 inverse cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    // AES-128 always runs ten rounds
    localparam int c_NR = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_INIT  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4
    } state_t;

    // Round constants for key-schedule steps 1..10 (entry 0 is step 1)
    localparam logic [7:0] c_RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One column, top byte is row 0
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
                gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
                gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
                gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Byte n = row + 4*col sits at s[127-8n -: 8]; row r rotates right by r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Forward AES S-box, shared with the aes_128 encryptor core.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    // Entry 0x00 is the most significant byte of the table
    localparam logic [2047:0] c_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_bit;

    // Byte a lives at bit offset 8*(255-a) = {~a, 3'b0}
    assign w_bit = {~i_a, 3'b000};
    assign o_y   = c_TABLE[w_bit +: 8];

endmodule
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox
//  Description : Inverse AES S-box, 8-bit combinational lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    // Entry 0x00 is the most significant byte of the table
    localparam logic [2047:0] c_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] w_bit;

    // Byte a lives at bit offset 8*(255-a) = {~a, 3'b0}
    assign w_bit = {~i_a, 3'b000};
    assign o_y   = c_TABLE[w_bit +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_128_dec.sv
`default_nettype none
// ============================================================================
//  Module      : aes_128_dec
//  Description : Iterative AES-128 inverse cipher. Expands the key schedule
//                on chip (10 cycles), then one inverse round per clock.
//                Optional macro AES_DEC_KEY_CACHE_EN skips key expansion when
//                the key matches the last fully expanded one.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_128_dec
    import aes_dec_pkg::*;
#(
    parameter int NR        = 10,
    parameter int DONE_HOLD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt
);

    if (NR != c_NR) begin : g_nr_check
        $error("aes_128_dec: NR must be 10 for AES-128");
    end

    state_t        r_st;
    state_t        w_st_nxt;
    logic          w_accept;
    logic          w_hit;
    logic [127:0]  r_state;
    logic [127:0]  r_rk [0:10];
    logic [3:0]    r_cnt;
    logic          r_done;
    logic [127:0]  r_pt;

    logic [127:0]  w_sr;
    logic [127:0]  w_sb;
    logic [127:0]  w_round;
    logic [127:0]  w_final;
    logic [127:0]  w_kprev;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [31:0]   w_temp;
    logic [127:0]  w_knext;

    // ---------------- inverse round datapath ----------------
    assign w_sr = inv_shift_rows(r_state);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        inv_sbox u_inv_sbox (
            .i_a (w_sr[8*i +: 8]),
            .o_y (w_sb[8*i +: 8])
        );
    end

    assign w_round = inv_mix_columns(w_sb ^ r_rk[r_cnt]);
    assign w_final = w_sb ^ r_rk[0];

    // ---------------- key schedule step ----------------
    assign w_kprev = r_rk[r_cnt - 4'd1];
    assign w_rot   = {w_kprev[23:0], w_kprev[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_fwd_sbox
        aes_sbox u_aes_sbox (
            .i_a (w_rot[8*j +: 8]),
            .o_y (w_sub[8*j +: 8])
        );
    end

    assign w_temp          = w_sub ^ {c_RCON[r_cnt - 4'd1], 24'h0};
    assign w_knext[127:96] = w_kprev[127:96] ^ w_temp;
    assign w_knext[95:64]  = w_kprev[95:64]  ^ w_knext[127:96];
    assign w_knext[63:32]  = w_kprev[63:32]  ^ w_knext[95:64];
    assign w_knext[31:0]   = w_kprev[31:0]   ^ w_knext[63:32];

    // ---------------- optional key cache ----------------
`ifdef AES_DEC_KEY_CACHE_EN
    // rk[0] doubles as the cached key; valid only once all 11 keys are built
    logic r_cache_valid;

    assign w_hit = r_cache_valid && (key == r_rk[0]);

    // Invalidate when expansion restarts, validate when it completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_valid <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_cache_valid <= 1'b0;
        end else if ((r_st == ST_KEXP) && (r_cnt == 4'd10)) begin
            r_cache_valid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // ---------------- control ----------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Next-state decode and acceptance strobe
    always_comb begin
        w_st_nxt = r_st;
        w_accept = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_st_nxt = w_hit ? ST_INIT : ST_KEXP;
                end
            end
            ST_KEXP:  if (r_cnt == 4'd10) w_st_nxt = ST_INIT;
            ST_INIT:  w_st_nxt = ST_ROUND;
            ST_ROUND: if (r_cnt == 4'd1) w_st_nxt = ST_FINAL;
            ST_FINAL: w_st_nxt = ST_IDLE;
            default:  w_st_nxt = ST_IDLE;
        endcase
    end

    // Round counter, done strobe and plaintext output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_pt   <= '0;
        end else begin
            if ((DONE_HOLD == 0) || w_accept) begin
                r_done <= 1'b0;
            end
            case (r_st)
                ST_IDLE:  if (start) r_cnt <= 4'd1;
                ST_KEXP:  r_cnt <= r_cnt + 4'd1;
                ST_INIT:  r_cnt <= 4'(c_NR - 1);
                ST_ROUND: r_cnt <= r_cnt - 4'd1;
                ST_FINAL: begin
                    r_pt   <= w_final;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Cipher state and round keys; pure datapath, so no reset
    always_ff @(posedge clk) begin
        case (r_st)
            ST_IDLE: begin
                if (start) begin
                    r_state <= ct;
                    r_rk[0] <= key;
                end
            end
            ST_KEXP:  r_rk[r_cnt] <= w_knext;
            ST_INIT:  r_state <= r_state ^ r_rk[c_NR];
            ST_ROUND: r_state <= w_round;
            default: ;
        endcase
    end

    assign busy = (r_st != ST_IDLE);
    assign done = r_done;
    assign pt   = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_128_dec
//  Description : Bench for aes_128_dec. Two instances (DONE_HOLD 0 and 1)
//                share stimulus; expected plaintexts come from FIPS-197
//                vectors and from a behavioural AES encryptor built from
//                GF(2^8) arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_dec;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] ct;
    logic [127:0] key;
    logic         busy0, done0, busy1, done1;
    logic [127:0] pt0, pt1;

    int           n_tests;
    int           n_fail;
    logic [7:0]   sbox_t [256];
    logic         m_valid;
    logic [127:0] m_key;

    localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PB = 128'h3243f6a8885a308d313198a2e0370734;

    aes_128_dec #(.NR(10), .DONE_HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .key(key),
        .busy(busy0), .done(done0), .pt(pt0)
    );

    aes_128_dec #(.NR(10), .DONE_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .key(key),
        .busy(busy1), .done(done1), .pt(pt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sbox_t[w[4*(i-1)+((j+1)%4)]];
                tmp[0] = tmp[0] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[4*c+r] = gf_mul(s[4*c+r], 8'h02) ^ gf_mul(s[4*c+(r+1)%4], 8'h03)
                                 ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One decrypt: accept, optionally poke start at edge poke_at, wait for done
    task automatic do_op(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] exp_pt, input int poke_at, input string tag);
        int n;
        int nb;
        int exp_lat;
`ifdef AES_DEC_KEY_CACHE_EN
        exp_lat = (m_valid && (k === m_key)) ? 11 : 21;
`else
        exp_lat = 21;
`endif
        key   = k;
        ct    = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_accept"}, 128'(busy0), 128'(1'b1));
        check({tag, " hold_cleared_on_accept"}, 128'(done1), 128'(1'b0));
        n  = 0;
        nb = 0;
        while (done0 !== 1'b1 && n < 40) begin
            if (busy0 === 1'b1) nb++;
            start = (n == poke_at - 1);
            ct    = rand128();
            key   = rand128();
            tick();
            n++;
        end
        start = 1'b0;
        m_valid = 1'b1;
        m_key   = k;
        check({tag, " latency"}, 128'(n), 128'(exp_lat));
        check({tag, " busy_cycles"}, 128'(nb), 128'(exp_lat));
        check({tag, " pt_pulse"}, pt0, exp_pt);
        check({tag, " pt_hold"}, pt1, exp_pt);
        check({tag, " done_hold_set"}, 128'(done1), 128'(1'b1));
        tick();
        check({tag, " done_pulse_width"}, 128'(done0), 128'(1'b0));
        check({tag, " done_hold_stays"}, 128'(done1), 128'(1'b1));
        check({tag, " idle_after_done"}, 128'(busy0), 128'(1'b0));
        check({tag, " pt_stable"}, pt0, exp_pt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]   inv;
        logic [127:0] rk;
        logic [127:0] rp;
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        m_key   = '0;

        // Forward S-box from multiplicative inverse plus affine transform
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        ct    = '0;
        key   = '0;
        tick();
        tick();
        check("reset busy", 128'(busy0), 128'(1'b0));
        check("reset done", 128'(done0), 128'(1'b0));
        check("reset pt", pt0, 128'h0);
        check("reset done_hold", 128'(done1), 128'(1'b0));
        rst = 1'b0;
        tick();

        // FIPS-197 C.1, then the same key again (cache hit when enabled)
        do_op(c_K1, c_C1, c_P1, -1, "c1_first");
        do_op(c_K1, c_C1, c_P1, -1, "c1_repeat");

        // FIPS-197 Appendix B with a new key
        do_op(c_KB, c_CB, c_PB, -1, "appb");

        // Start pulse with other data while busy must be ignored
        do_op(c_KB, c_CB, c_PB, 5, "start_while_busy");

        // Reset at the 14th edge after acceptance
        key   = c_K1;
        ct    = c_C1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 1'b0;
        check("abort busy", 128'(busy0), 128'(1'b0));
        check("abort done", 128'(done0), 128'(1'b0));
        check("abort pt", pt0, 128'h0);
        check("abort pt_hold", pt1, 128'h0);
        check("abort done_hold", 128'(done1), 128'(1'b0));
        do_op(c_K1, c_C1, c_P1, -1, "after_abort");

        // Round trips through the behavioural encryptor
        for (int i = 0; i < 200; i++) begin
            rk = rand128();
            rp = rand128();
            do_op(rk, m_encrypt(rk, rp), rp, -1, "round_trip");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
